frame_buf_ctrl: RTL and testbench
=================================

// Module: frame_buf_ctrl
// PURPOSE
//  Double-buffered frame sequencer that sits directly upstream of sdram_core on clk_143.
//  It drains the camera FIFO into SDRAM in fixed-length write bursts, ping-ponging between two frame regions.
//  On request it streams the last completed frame back out as single-word reads toward the SPI FIFO.
//  Only one SDRAM request is outstanding at a time; writes have priority over reads.
// PARAMETERS
//  APP_ADDR_WIDTH   24     sdram_core application address width; MSB selects frame region (bank 0/1)
//  USED_WIDTH       10     width of camera FIFO rdusedw
//  BURST_LEN        256    words per write burst; FRAME_WORDS must be a multiple of it
//  FRAME_WORDS      65536  words per frame; must be < 2**(APP_ADDR_WIDTH-1)
// PORTS
//  clk              in   1   system clock (clk_143)
//  nrst             in   1   asynchronous reset, active low
//  fifo_rdusedw     in   USED_WIDTH  camera FIFO fill level (read side)
//  frame_sync       in   1   one-cycle pulse at the start of each camera frame
//  rd_start         in   1   one-cycle pulse requesting readout of the completed frame
//  out_fifo_full    in   1   SPI FIFO write-side full flag
//  wr_burst_req     out  1   write request to sdram_core; held until wr_burst_finish
//  wr_burst_addr    out  APP_ADDR_WIDTH  write base address, stable while wr_burst_req=1
//  wr_burst_finish  in   1   one-cycle pulse: write burst complete
//  rd_burst_req     out  1   single-word read request; held until rd_burst_finish
//  rd_burst_addr    out  APP_ADDR_WIDTH  read address, stable while rd_burst_req=1
//  rd_burst_finish  in   1   one-cycle pulse: read complete
//  frame_valid      out  1   a completed, unread frame exists in rd_bank
//  reading          out  1   frame readout in progress
//  drop_cnt         out  8   completed frames dropped due to an active readout; saturates at 255
// BEHAVIOUR
//  Reset (nrst=0, async):
//   - All outputs are 0; state = IDLE; wr_bank=0, rd_bank=0.
//   - wr_off=0, rd_off=0, sync_pend=0.
//  FSM states: IDLE, WR_BUSY, RD_BUSY.
//   - IDLE->WR_BUSY when fifo_rdusedw >= BURST_LEN; wr_burst_req rises next cycle.
//     wr_burst_addr = {wr_bank, wr_off}.
//   - IDLE->RD_BUSY when no write is eligible, reading=1 and out_fifo_full=0.
//     rd_burst_addr = {rd_bank, rd_off}.
//   - WR_BUSY->IDLE on wr_burst_finish; RD_BUSY->IDLE on rd_burst_finish.
//   - The request drops in the same edge that leaves the state, so each request is low for >=1 cycle between transactions.
//   - finish pulses seen outside the matching BUSY state are ignored.
//  Write completion (finish in WR_BUSY):
//   - wr_off += BURST_LEN. If wr_off reaches FRAME_WORDS, the frame is complete and wr_off=0.
//   - If reading=0: rd_bank<=wr_bank, wr_bank toggles, frame_valid=1 (an older unread frame is overwritten, no drop).
//   - If reading=1: banks unchanged and the frame is discarded; drop_cnt++ (saturating at 255).
//  frame_sync:
//   - In IDLE, the write-side realignment takes effect immediately: wr_off=0.
//   - In WR_BUSY, it sets sync_pend; on finish the realignment applies instead of wr_off+=BURST_LEN, and the partial frame is discarded.
//   - If frame_sync coincides with the finish, the realignment wins.
//  Readout:
//   - rd_start with frame_valid=1 and reading=0 sets reading=1, rd_off=0 and frame_valid=0. Otherwise it is ignored.
//   - On each read finish rd_off++. A finish at rd_off = FRAME_WORDS-1 clears reading and sets rd_off=0.
//   - out_fifo_full only gates new read requests; it never aborts one already issued.
//  Reset mid-burst: everything returns to reset values immediately; sdram_core is reset by the same event.
// TESTING (bench uses BURST_LEN=256, FRAME_WORDS=512)
//  1 rdusedw=300 in IDLE -> wr_burst_req=1 next cycle, addr=0x000000.
//    After finish, rdusedw=300 -> second req addr=0x000100.
//    After finish: frame_valid=1, rd_bank=0, next write addr=0x800000.
//  2 rd_start after test 1, out_fifo_full=0 -> 512 read reqs, addrs 0x000000..0x0001FF.
//    reading falls after finish #512; frame_valid=0 throughout.
//  3 rdusedw=300 during readout -> the write preempts between reads (next request is the write).
//    Reads resume at the unchanged rd_off.
//  4 Frame completes while reading=1 -> drop_cnt 0->1, wr_bank unchanged, next write addr={wr_bank, 0x000}.
//  5 frame_sync during WR_BUSY at wr_off=0x000 -> after finish the next addr is still wr_off 0x000, frame_valid unchanged.
//  6 out_fifo_full=1 during readout -> no new rd_burst_req; an issued req completes.
//    Clear -> the next req addr = previous+1.
//    nrst pulse mid-read -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/frame_buf_ctrl_if.sv
// Bus bundle between frame_buf_ctrl and its environment (camera FIFO,
// sdram_core request channels, SPI FIFO flag and status outputs).
//   master : frame_buf_ctrl side (drives requests, addresses and status)
//   slave  : environment side (drives FIFO level, pulses and finish strobes)
interface frame_buf_ctrl_if #(
    parameter int unsigned APP_ADDR_WIDTH = 24,
    parameter int unsigned USED_WIDTH     = 10
);
    logic [USED_WIDTH-1:0]     fifo_rdusedw;
    logic                      frame_sync;
    logic                      rd_start;
    logic                      out_fifo_full;
    logic                      wr_burst_req;
    logic [APP_ADDR_WIDTH-1:0] wr_burst_addr;
    logic                      wr_burst_finish;
    logic                      rd_burst_req;
    logic [APP_ADDR_WIDTH-1:0] rd_burst_addr;
    logic                      rd_burst_finish;
    logic                      frame_valid;
    logic                      reading;
    logic [7:0]                drop_cnt;

    modport master (
        input  fifo_rdusedw, frame_sync, rd_start, out_fifo_full,
               wr_burst_finish, rd_burst_finish,
        output wr_burst_req, wr_burst_addr, rd_burst_req, rd_burst_addr,
               frame_valid, reading, drop_cnt
    );

    modport slave (
        output fifo_rdusedw, frame_sync, rd_start, out_fifo_full,
               wr_burst_finish, rd_burst_finish,
        input  wr_burst_req, wr_burst_addr, rd_burst_req, rd_burst_addr,
               frame_valid, reading, drop_cnt
    );
endinterface

// File: rtl/frame_buf_ctrl.sv
// Double-buffered frame sequencer in front of sdram_core.
// Drains the camera FIFO into SDRAM in fixed bursts, ping-ponging between two
// frame regions (address MSB), and streams the last completed frame back out
// as single-word reads. One SDRAM request outstanding; writes beat reads.
// Ports:
//   clk  : system clock (clk_143)
//   nrst : asynchronous reset, active low
//   bus  : frame_buf_ctrl_if master modport (FIFO level, sync/start pulses,
//          write/read request channels, frame_valid/reading/drop_cnt status)
module frame_buf_ctrl #(
    parameter int unsigned APP_ADDR_WIDTH = 24,
    parameter int unsigned USED_WIDTH     = 10,
    parameter int unsigned BURST_LEN      = 256,
    parameter int unsigned FRAME_WORDS    = 65536
) (
    input  logic             clk,
    input  logic             nrst,
    frame_buf_ctrl_if.master bus
);
    localparam int unsigned OFF_W = APP_ADDR_WIDTH - 1;
    localparam int unsigned UW1   = USED_WIDTH + 1;
    localparam logic [OFF_W-1:0] BURST_OFF  = OFF_W'(BURST_LEN);
    localparam logic [OFF_W-1:0] FRAME_END  = OFF_W'(FRAME_WORDS);
    localparam logic [OFF_W-1:0] LAST_RD    = OFF_W'(FRAME_WORDS - 1);
    localparam logic [UW1-1:0]   BURST_USED = UW1'(BURST_LEN);

    typedef enum logic [1:0] {IDLE, WR_BUSY, RD_BUSY} state_t;

    state_t                    r_state,     w_state_nxt;
    logic                      r_wr_bank,   w_wr_bank_nxt;
    logic                      r_rd_bank,   w_rd_bank_nxt;
    logic [OFF_W-1:0]          r_wr_off,    w_wr_off_nxt;
    logic [OFF_W-1:0]          r_rd_off,    w_rd_off_nxt;
    logic                      r_sync_pend, w_sync_pend_nxt;
    logic                      r_frame_valid, w_frame_valid_nxt;
    logic                      r_reading,   w_reading_nxt;
    logic [7:0]                r_drop_cnt,  w_drop_cnt_nxt;
    logic                      r_wr_req,    w_wr_req_nxt;
    logic [APP_ADDR_WIDTH-1:0] r_wr_addr,   w_wr_addr_nxt;
    logic                      r_rd_req,    w_rd_req_nxt;
    logic [APP_ADDR_WIDTH-1:0] r_rd_addr,   w_rd_addr_nxt;

    logic             w_rd_accept;
    logic             w_wr_elig;
    logic             w_frame_done;
    logic [OFF_W-1:0] w_wr_off_inc;

    assign w_rd_accept  = bus.rd_start && r_frame_valid && !r_reading;
    assign w_wr_elig    = {1'b0, bus.fifo_rdusedw} >= BURST_USED;
    assign w_wr_off_inc = r_wr_off + BURST_OFF;

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt       = r_state;
        w_wr_bank_nxt     = r_wr_bank;
        w_rd_bank_nxt     = r_rd_bank;
        w_wr_off_nxt      = r_wr_off;
        w_rd_off_nxt      = r_rd_off;
        w_sync_pend_nxt   = r_sync_pend;
        w_frame_valid_nxt = r_frame_valid;
        w_reading_nxt     = r_reading;
        w_drop_cnt_nxt    = r_drop_cnt;
        w_wr_req_nxt      = r_wr_req;
        w_wr_addr_nxt     = r_wr_addr;
        w_rd_req_nxt      = r_rd_req;
        w_rd_addr_nxt     = r_rd_addr;
        w_frame_done      = 1'b0;

        if (w_rd_accept) begin
            w_reading_nxt     = 1'b1;
            w_rd_off_nxt      = '0;
            w_frame_valid_nxt = 1'b0;
        end

        case (r_state)
            IDLE: begin
                // No write in flight: realign at once, and a burst launched
                // in this same cycle already starts at offset 0.
                if (bus.frame_sync) w_wr_off_nxt = '0;
                if (w_wr_elig) begin
                    w_state_nxt   = WR_BUSY;
                    w_wr_req_nxt  = 1'b1;
                    w_wr_addr_nxt = {r_wr_bank, w_wr_off_nxt};
                end else if (r_reading && !bus.out_fifo_full) begin
                    w_state_nxt   = RD_BUSY;
                    w_rd_req_nxt  = 1'b1;
                    w_rd_addr_nxt = {r_rd_bank, r_rd_off};
                end
            end
            WR_BUSY: begin
                if (bus.wr_burst_finish) begin
                    w_state_nxt     = IDLE;
                    w_wr_req_nxt    = 1'b0;
                    w_sync_pend_nxt = 1'b0;
                    if (r_sync_pend || bus.frame_sync) begin
                        w_wr_off_nxt = '0;
                    end else if (w_wr_off_inc == FRAME_END) begin
                        w_wr_off_nxt = '0;
                        w_frame_done = 1'b1;
                    end else begin
                        w_wr_off_nxt = w_wr_off_inc;
                    end
                end else if (bus.frame_sync) begin
                    w_sync_pend_nxt = 1'b1;
                end
            end
            RD_BUSY: begin
                if (bus.frame_sync) w_wr_off_nxt = '0;
                if (bus.rd_burst_finish) begin
                    w_state_nxt  = IDLE;
                    w_rd_req_nxt = 1'b0;
                    if (r_rd_off == LAST_RD) begin
                        w_reading_nxt = 1'b0;
                        w_rd_off_nxt  = '0;
                    end else begin
                        w_rd_off_nxt = r_rd_off + 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Completed frame: publish it, or drop it if a readout owns rd_bank.
        if (w_frame_done) begin
            if (r_reading || w_rd_accept) begin
                if (r_drop_cnt != 8'hFF) w_drop_cnt_nxt = r_drop_cnt + 8'd1;
            end else begin
                w_rd_bank_nxt     = r_wr_bank;
                w_wr_bank_nxt     = ~r_wr_bank;
                w_frame_valid_nxt = 1'b1;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state       <= IDLE;
            r_wr_bank     <= 1'b0;
            r_rd_bank     <= 1'b0;
            r_wr_off      <= '0;
            r_rd_off      <= '0;
            r_sync_pend   <= 1'b0;
            r_frame_valid <= 1'b0;
            r_reading     <= 1'b0;
            r_drop_cnt    <= 8'd0;
            r_wr_req      <= 1'b0;
            r_wr_addr     <= '0;
            r_rd_req      <= 1'b0;
            r_rd_addr     <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_wr_bank     <= w_wr_bank_nxt;
            r_rd_bank     <= w_rd_bank_nxt;
            r_wr_off      <= w_wr_off_nxt;
            r_rd_off      <= w_rd_off_nxt;
            r_sync_pend   <= w_sync_pend_nxt;
            r_frame_valid <= w_frame_valid_nxt;
            r_reading     <= w_reading_nxt;
            r_drop_cnt    <= w_drop_cnt_nxt;
            r_wr_req      <= w_wr_req_nxt;
            r_wr_addr     <= w_wr_addr_nxt;
            r_rd_req      <= w_rd_req_nxt;
            r_rd_addr     <= w_rd_addr_nxt;
        end
    end

    assign bus.wr_burst_req  = r_wr_req;
    assign bus.wr_burst_addr = r_wr_addr;
    assign bus.rd_burst_req  = r_rd_req;
    assign bus.rd_burst_addr = r_rd_addr;
    assign bus.frame_valid   = r_frame_valid;
    assign bus.reading       = r_reading;
    assign bus.drop_cnt      = r_drop_cnt;
endmodule

// File: tb/tb_frame_buf_ctrl.sv
// Directed self-checking bench for frame_buf_ctrl (BURST_LEN=256, FRAME_WORDS=512).
module tb_frame_buf_ctrl;
    logic clk;
    logic nrst;
    int   errors = 0;
    int   checks = 0;
    int   exp_rd = 0;

    frame_buf_ctrl_if #(.APP_ADDR_WIDTH(24), .USED_WIDTH(10)) bus ();

    frame_buf_ctrl #(
        .APP_ADDR_WIDTH(24), .USED_WIDTH(10), .BURST_LEN(256), .FRAME_WORDS(512)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_wr(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.wr_burst_req) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic wait_rd(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.rd_burst_req) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic fin_wr();
        bus.wr_burst_finish = 1'b1;
        tick();
        bus.wr_burst_finish = 1'b0;
    endtask

    task automatic fin_rd();
        bus.rd_burst_finish = 1'b1;
        tick();
        bus.rd_burst_finish = 1'b0;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        bus.fifo_rdusedw = '0; bus.frame_sync = 0; bus.rd_start = 0;
        bus.out_fifo_full = 0; bus.wr_burst_finish = 0; bus.rd_burst_finish = 0;
        tick(); tick();
        checks++;
        if ({bus.wr_burst_req, bus.rd_burst_req, bus.frame_valid, bus.reading} !== 4'b0 ||
            bus.wr_burst_addr !== 24'h0 || bus.rd_burst_addr !== 24'h0 || bus.drop_cnt !== 8'h0) begin
            errors++; $display("FAIL reset_outputs got wr=%b rd=%b fv=%b rdg=%b drop=%0d required all 0",
                bus.wr_burst_req, bus.rd_burst_req, bus.frame_valid, bus.reading, bus.drop_cnt);
        end
        nrst = 1'b1;
        tick();
        fin_wr(); fin_rd(); tick();
        checks++;
        if (bus.wr_burst_req !== 1'b0 || bus.rd_burst_req !== 1'b0 || bus.frame_valid !== 1'b0) begin
            errors++; $display("FAIL stray_finish got wr=%b rd=%b fv=%b required 0 0 0",
                bus.wr_burst_req, bus.rd_burst_req, bus.frame_valid);
        end
    endtask

    task automatic test_write_frame();
        bus.fifo_rdusedw = 10'd300;
        tick();
        checks++;
        if (bus.wr_burst_req !== 1'b1 || bus.wr_burst_addr !== 24'h000000) begin
            errors++; $display("FAIL wr1_req got req=%b addr=%h required 1 000000", bus.wr_burst_req, bus.wr_burst_addr);
        end
        tick(); tick();
        checks++;
        if (bus.wr_burst_req !== 1'b1) begin
            errors++; $display("FAIL wr1_hold got %b required 1", bus.wr_burst_req);
        end
        fin_wr();
        checks++;
        if (bus.wr_burst_req !== 1'b0) begin
            errors++; $display("FAIL wr1_drop got %b required 0", bus.wr_burst_req);
        end
        tick();
        checks++;
        if (bus.wr_burst_req !== 1'b1 || bus.wr_burst_addr !== 24'h000100) begin
            errors++; $display("FAIL wr2_req got req=%b addr=%h required 1 000100", bus.wr_burst_req, bus.wr_burst_addr);
        end
        bus.fifo_rdusedw = 10'd0;
        checks++;
        if (bus.frame_valid !== 1'b0) begin
            errors++; $display("FAIL fv_before_done got %b required 0", bus.frame_valid);
        end
        fin_wr();
        checks++;
        if (bus.frame_valid !== 1'b1) begin
            errors++; $display("FAIL fv_after_frame got %b required 1", bus.frame_valid);
        end
        bus.fifo_rdusedw = 10'd300;
        tick();
        checks++;
        if (bus.wr_burst_req !== 1'b1 || bus.wr_burst_addr !== 24'h800000) begin
            errors++; $display("FAIL wr_bank1 got req=%b addr=%h required 1 800000", bus.wr_burst_req, bus.wr_burst_addr);
        end
        bus.fifo_rdusedw = 10'd0;
        fin_wr();
    endtask

    task automatic test_readout_full();
        bit ok;
        bus.rd_start = 1'b1;
        tick();
        bus.rd_start = 1'b0;
        checks++;
        if (bus.reading !== 1'b1 || bus.frame_valid !== 1'b0) begin
            errors++; $display("FAIL rd_start got reading=%b fv=%b required 1 0", bus.reading, bus.frame_valid);
        end
        for (int i = 0; i < 512; i++) begin
            wait_rd(ok);
            checks++;
            if (!ok || bus.rd_burst_addr !== 24'(i) || bus.frame_valid !== 1'b0) begin
                errors++; $display("FAIL read_addr i=%0d got ok=%b addr=%h fv=%b required 1 %h 0",
                    i, ok, bus.rd_burst_addr, bus.frame_valid, 24'(i));
                if (!ok) break;
            end
            if (i == 511) begin
                checks++;
                if (bus.reading !== 1'b1) begin
                    errors++; $display("FAIL reading_before_last got %b required 1", bus.reading);
                end
            end
            fin_rd();
        end
        checks++;
        if (bus.reading !== 1'b0 || bus.rd_burst_req !== 1'b0) begin
            errors++; $display("FAIL readout_end got reading=%b req=%b required 0 0", bus.reading, bus.rd_burst_req);
        end
        tick(); tick();
        checks++;
        if (bus.rd_burst_req !== 1'b0) begin
            errors++; $display("FAIL no_read_after_end got %b required 0", bus.rd_burst_req);
        end
    endtask

    task automatic test_write_preempt();
        bit ok;
        // Finish the bank-1 frame while idle: it becomes the readable frame.
        bus.fifo_rdusedw = 10'd300;
        wait_wr(ok);
        checks++;
        if (!ok || bus.wr_burst_addr !== 24'h800100) begin
            errors++; $display("FAIL wr_bank1_second got ok=%b addr=%h required 1 800100", ok, bus.wr_burst_addr);
        end
        bus.fifo_rdusedw = 10'd0;
        fin_wr();
        bus.rd_start = 1'b1;
        tick();
        bus.rd_start = 1'b0;
        exp_rd = 0;
        for (int i = 0; i < 4; i++) begin
            wait_rd(ok);
            checks++;
            if (!ok || bus.rd_burst_addr !== 24'h800000 + 24'(exp_rd)) begin
                errors++; $display("FAIL rd_bank1 i=%0d got ok=%b addr=%h required 1 %h",
                    i, ok, bus.rd_burst_addr, 24'h800000 + 24'(exp_rd));
            end
            if (i == 3) bus.fifo_rdusedw = 10'd300;
            fin_rd();
            exp_rd++;
        end
        tick();
        checks++;
        if (bus.wr_burst_req !== 1'b1 || bus.rd_burst_req !== 1'b0 || bus.wr_burst_addr !== 24'h000000) begin
            errors++; $display("FAIL preempt got wr=%b rd=%b addr=%h required 1 0 000000",
                bus.wr_burst_req, bus.rd_burst_req, bus.wr_burst_addr);
        end
        bus.fifo_rdusedw = 10'd0;
        fin_wr();
        wait_rd(ok);
        checks++;
        if (!ok || bus.rd_burst_addr !== 24'h800004) begin
            errors++; $display("FAIL read_resume got ok=%b addr=%h required 1 800004", ok, bus.rd_burst_addr);
        end
    endtask

    task automatic test_drop();
        bit ok;
        bus.fifo_rdusedw = 10'd300;
        fin_rd(); exp_rd++;
        wait_wr(ok);
        checks++;
        if (!ok || bus.wr_burst_addr !== 24'h000100) begin
            errors++; $display("FAIL drop_wr_addr got ok=%b addr=%h required 1 000100", ok, bus.wr_burst_addr);
        end
        bus.fifo_rdusedw = 10'd0;
        fin_wr();
        checks++;
        if (bus.drop_cnt !== 8'd1 || bus.frame_valid !== 1'b0 || bus.reading !== 1'b1) begin
            errors++; $display("FAIL drop_cnt got drop=%0d fv=%b reading=%b required 1 0 1",
                bus.drop_cnt, bus.frame_valid, bus.reading);
        end
        wait_rd(ok);
        checks++;
        if (!ok || bus.rd_burst_addr !== 24'h800005) begin
            errors++; $display("FAIL drop_rd_addr got ok=%b addr=%h required 1 800005", ok, bus.rd_burst_addr);
        end
        bus.fifo_rdusedw = 10'd300;
        fin_rd(); exp_rd++;
        wait_wr(ok);
        checks++;
        if (!ok || bus.wr_burst_addr !== 24'h000000) begin
            errors++; $display("FAIL drop_bank_kept got ok=%b addr=%h required 1 000000", ok, bus.wr_burst_addr);
        end
    endtask

    task automatic test_frame_sync();
        bit ok;
        // Write at wr_off 0 is in flight from test_drop.
        bus.frame_sync = 1'b1;
        tick();
        bus.frame_sync = 1'b0;
        bus.fifo_rdusedw = 10'd0;
        fin_wr();
        checks++;
        if (bus.frame_valid !== 1'b0 || bus.drop_cnt !== 8'd1) begin
            errors++; $display("FAIL sync_status got fv=%b drop=%0d required 0 1", bus.frame_valid, bus.drop_cnt);
        end
        wait_rd(ok);
        checks++;
        if (!ok || bus.rd_burst_addr !== 24'h800006) begin
            errors++; $display("FAIL sync_rd_addr got ok=%b addr=%h required 1 800006", ok, bus.rd_burst_addr);
        end
        bus.fifo_rdusedw = 10'd300;
        fin_rd(); exp_rd++;
        wait_wr(ok);
        checks++;
        if (!ok || bus.wr_burst_addr !== 24'h000000) begin
            errors++; $display("FAIL sync_realign got ok=%b addr=%h required 1 000000", ok, bus.wr_burst_addr);
        end
        bus.fifo_rdusedw = 10'd0;
        fin_wr();
    endtask

    task automatic test_backpressure_reset();
        bit ok;
        wait_rd(ok);
        checks++;
        if (!ok || bus.rd_burst_addr !== 24'h800007) begin
            errors++; $display("FAIL bp_rd_addr got ok=%b addr=%h required 1 800007", ok, bus.rd_burst_addr);
        end
        bus.out_fifo_full = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (bus.rd_burst_req !== 1'b1) begin
            errors++; $display("FAIL bp_no_abort got %b required 1", bus.rd_burst_req);
        end
        fin_rd(); exp_rd++;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (bus.rd_burst_req !== 1'b0) begin
            errors++; $display("FAIL bp_gated got %b required 0", bus.rd_burst_req);
        end
        bus.out_fifo_full = 1'b0;
        wait_rd(ok);
        checks++;
        if (!ok || bus.rd_burst_addr !== 24'h800008) begin
            errors++; $display("FAIL bp_resume got ok=%b addr=%h required 1 800008", ok, bus.rd_burst_addr);
        end
        nrst = 1'b0;
        #1;
        checks++;
        if ({bus.wr_burst_req, bus.rd_burst_req, bus.frame_valid, bus.reading} !== 4'b0 ||
            bus.wr_burst_addr !== 24'h0 || bus.rd_burst_addr !== 24'h0 || bus.drop_cnt !== 8'h0) begin
            errors++; $display("FAIL async_reset got wr=%b rd=%b rdaddr=%h rdg=%b drop=%0d required all 0",
                bus.wr_burst_req, bus.rd_burst_req, bus.rd_burst_addr, bus.reading, bus.drop_cnt);
        end
        @(negedge clk);
        nrst = 1'b1;
        tick(); tick();
        checks++;
        if (bus.rd_burst_req !== 1'b0 || bus.reading !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle got rd=%b reading=%b required 0 0", bus.rd_burst_req, bus.reading);
        end
    endtask

    initial begin
        test_reset();
        test_write_frame();
        test_readout_full();
        test_write_preempt();
        test_drop();
        test_frame_sync();
        test_backpressure_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
